// File: rtl/audio_fb_pkg.sv
// Shared definitions for the audio frame buffer: register map helpers,
// CTRL bit positions and the capture state encoding.
package audio_fb_pkg;

    typedef enum logic [1:0] {
        FB_IDLE = 2'd0,
        FB_FILL = 2'd1,
        FB_FULL = 2'd2
    } fb_state_e;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_ACK_BIT   = 1;
    localparam int unsigned CTRL_IE_BIT    = 2;
    localparam int unsigned CTRL_CLR_BIT   = 3;
    localparam int unsigned CTRL_READY_BIT = 3;
    localparam int unsigned CTRL_BANK_BIT  = 4;

    function automatic int unsigned fb_result_base(input int unsigned depth);
        return depth;
    endfunction

    function automatic int unsigned fb_ctrl_addr(input int unsigned depth);
        return 2 * depth;
    endfunction

    function automatic int unsigned fb_status_addr(input int unsigned depth);
        return 2 * depth + 1;
    endfunction

endpackage

// File: rtl/audio_fb_fsm.sv
// Capture sequencer: write pointer, ping-pong bank select, frame ownership
// flag and the frame/drop counters.
module audio_fb_fsm
    import audio_fb_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     sample_valid,
    input  logic                     ack,
    input  logic                     clr,
    output logic                     cap_we,
    output logic [$clog2(DEPTH)-1:0] wptr,
    output logic                     host_bank,
    output logic                     frame_ready,
    output logic [15:0]              frame_count,
    output logic [15:0]              drop_count
);

    localparam int unsigned LW   = $clog2(DEPTH);
    localparam logic [LW-1:0] LAST = LW'(DEPTH - 1);

    fb_state_e     state_r;
    logic [LW-1:0] wptr_r;
    logic          host_bank_r;
    logic          frame_ready_r;
    logic [15:0]   frame_count_r;
    logic [15:0]   drop_count_r;
    logic          swap_s;
    logic          drop_s;

    // A completed frame is handed over only once the host has released the previous one.
    assign swap_s = (state_r == FB_FULL) && en && !frame_ready_r;
    assign drop_s = (state_r == FB_FULL) && sample_valid;
    assign cap_we = (state_r == FB_FILL) && en && sample_valid;

    // State, pointer, bank select, ownership flag and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FB_IDLE;
            wptr_r        <= '0;
            host_bank_r   <= 1'b0;
            frame_ready_r <= 1'b0;
            frame_count_r <= 16'd0;
            drop_count_r  <= 16'd0;
        end else begin
            case (state_r)
                FB_IDLE: begin
                    wptr_r  <= '0;
                    state_r <= en ? FB_FILL : FB_IDLE;
                end
                FB_FILL: begin
                    if (!en) begin
                        state_r <= FB_IDLE;
                        wptr_r  <= '0;
                    end else if (sample_valid) begin
                        wptr_r <= wptr_r + 1'b1;
                        if (wptr_r == LAST) begin
                            state_r <= FB_FULL;
                        end
                    end
                end
                FB_FULL: begin
                    if (!en) begin
                        state_r <= FB_IDLE;
                        wptr_r  <= '0;
                    end else if (swap_s) begin
                        host_bank_r <= ~host_bank_r;
                        wptr_r      <= '0;
                        state_r     <= FB_FILL;
                    end
                end
                default: begin
                    state_r <= FB_IDLE;
                    wptr_r  <= '0;
                end
            endcase

            if (swap_s) begin
                frame_ready_r <= 1'b1;
            end else if (ack && frame_ready_r) begin
                frame_ready_r <= 1'b0;
            end

            if (clr) begin
                frame_count_r <= 16'd0;
                drop_count_r  <= 16'd0;
            end else begin
                if (swap_s) begin
                    frame_count_r <= frame_count_r + 16'd1;
                end
                if (drop_s && (drop_count_r != 16'hFFFF)) begin
                    drop_count_r <= drop_count_r + 16'd1;
                end
            end
        end
    end

    assign wptr        = wptr_r;
    assign host_bank   = host_bank_r;
    assign frame_ready = frame_ready_r;
    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong audio frame capture with an Avalon-MM host port, a host-written
// result array exported in parallel, and frame/drop status.
module audio_frame_buffer
    import audio_fb_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  AVL_READ,
    input  logic                  AVL_WRITE,
    input  logic                  AVL_CS,
    input  logic [3:0]            AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]     AVL_ADDR,
    input  logic [31:0]           AVL_WRITEDATA,
    output logic [31:0]           AVL_READDATA,
    input  logic [SAMPLE_W-1:0]   SAMPLE_IN,
    input  logic                  SAMPLE_VALID,
    output logic                  IRQ,
    output logic [32*DEPTH-1:0]   RESULT_OUT,
    output logic [31:0]           EXPORT_DATA
);

    localparam int unsigned LW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(fb_ctrl_addr(DEPTH));
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(fb_status_addr(DEPTH));
    localparam logic [ADDR_W-1:0] RES_REG  = ADDR_W'(fb_result_base(DEPTH) >> LW);

    logic                wr_s;
    logic                rd_s;
    logic [ADDR_W-1:0]   region_s;
    logic                is_sample_s;
    logic                is_result_s;
    logic [LW-1:0]       idx_s;
    logic                ctrl_wr_s;
    logic                ack_s;
    logic                clr_s;
    logic                en_r;
    logic                ie_r;
    logic [31:0]         result_r [DEPTH];
    logic [SAMPLE_W-1:0] mem_r [2*DEPTH];
    logic [SAMPLE_W-1:0] sample_q_r;
    logic                rd_sample_r;
    logic [31:0]         rd_word_r;
    logic [31:0]         reg_rd_s;
    logic                cap_we_s;
    logic [LW-1:0]       wptr_s;
    logic                host_bank_s;
    logic                frame_ready_s;
    logic [15:0]         frame_count_s;
    logic [15:0]         drop_count_s;

    assign wr_s        = AVL_CS && AVL_WRITE;
    assign rd_s        = AVL_CS && AVL_READ;
    assign region_s    = AVL_ADDR >> LW;
    assign is_sample_s = (region_s == '0);
    assign is_result_s = (region_s == RES_REG);
    assign idx_s       = AVL_ADDR[LW-1:0];
    assign ctrl_wr_s   = wr_s && (AVL_ADDR == CTRL_A);
    assign ack_s       = ctrl_wr_s && AVL_WRITEDATA[CTRL_ACK_BIT];
    assign clr_s       = ctrl_wr_s && AVL_WRITEDATA[CTRL_CLR_BIT];

    audio_fb_fsm #(
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk          (CLK),
        .reset        (RESET),
        .en           (en_r),
        .sample_valid (SAMPLE_VALID),
        .ack          (ack_s),
        .clr          (clr_s),
        .cap_we       (cap_we_s),
        .wptr         (wptr_s),
        .host_bank    (host_bank_s),
        .frame_ready  (frame_ready_s),
        .frame_count  (frame_count_s),
        .drop_count   (drop_count_s)
    );

    // Stored CTRL bits; ACK and CLR are single-cycle pulses and never stored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            en_r <= 1'b0;
            ie_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            en_r <= AVL_WRITEDATA[CTRL_EN_BIT];
            ie_r <= AVL_WRITEDATA[CTRL_IE_BIT];
        end
    end

    // Byte-enabled result array writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                result_r[k] <= 32'd0;
            end
        end else if (wr_s && is_result_s) begin
            for (int b = 0; b < 4; b++) begin
                if (AVL_BYTE_EN[b]) begin
                    result_r[idx_s][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                end
            end
        end
    end

    // Sample storage: capture writes the bank the host does not own; reads are synchronous.
    always_ff @(posedge CLK) begin
        if (cap_we_s) begin
            mem_r[{~host_bank_s, wptr_s}] <= SAMPLE_IN;
        end
        if (rd_s && is_sample_s) begin
            sample_q_r <= mem_r[{host_bank_s, idx_s}];
        end
    end

    // Register-side read data for non-sample addresses.
    always_comb begin
        reg_rd_s = 32'd0;
        if (is_result_s) begin
            reg_rd_s = result_r[idx_s];
        end else if (AVL_ADDR == CTRL_A) begin
            reg_rd_s[CTRL_EN_BIT]    = en_r;
            reg_rd_s[CTRL_IE_BIT]    = ie_r;
            reg_rd_s[CTRL_READY_BIT] = frame_ready_s;
            reg_rd_s[CTRL_BANK_BIT]  = host_bank_s;
        end else if (AVL_ADDR == STATUS_A) begin
            reg_rd_s = {drop_count_s, frame_count_s};
        end else begin
            reg_rd_s = 32'd0;
        end
    end

    // Read path registers; both hold until the next read is accepted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_sample_r <= 1'b0;
            rd_word_r   <= 32'd0;
        end else if (rd_s) begin
            rd_sample_r <= is_sample_s;
            rd_word_r   <= reg_rd_s;
        end
    end

    assign AVL_READDATA = rd_sample_r ? 32'(signed'(sample_q_r)) : rd_word_r;

    // Parallel export: result[0] lands in the most significant word.
    always_comb begin
        RESULT_OUT = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            RESULT_OUT[32*(int'(DEPTH)-1-k) +: 32] = result_r[k];
        end
    end

    assign IRQ         = frame_ready_s && ie_r;
    assign EXPORT_DATA = {drop_count_s, frame_count_s};

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Randomised scoreboard bench for audio_frame_buffer against a frame-level
// reference model (sample queue, host frame copy, ownership flag, counters).
module tb_audio_frame_buffer;

    localparam int DEPTH = 8;
    localparam int SW    = 24;
    localparam int AW    = 6;
    localparam int CTRL  = 2 * DEPTH;
    localparam int STAT  = 2 * DEPTH + 1;

    logic                 clk = 1'b0;
    logic                 RESET;
    logic                 AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]           AVL_BYTE_EN;
    logic [AW-1:0]        AVL_ADDR;
    logic [31:0]          AVL_WRITEDATA;
    logic [31:0]          AVL_READDATA;
    logic [SW-1:0]        SAMPLE_IN;
    logic                 SAMPLE_VALID;
    logic                 IRQ;
    logic [32*DEPTH-1:0]  RESULT_OUT;
    logic [31:0]          EXPORT_DATA;

    audio_frame_buffer #(.DEPTH(DEPTH), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
        .CLK(clk), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .SAMPLE_IN(SAMPLE_IN), .SAMPLE_VALID(SAMPLE_VALID), .IRQ(IRQ),
        .RESULT_OUT(RESULT_OUT), .EXPORT_DATA(EXPORT_DATA)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    bit          m_en, m_ie, m_fr, m_full, m_bank;
    int          m_busy;
    logic [15:0] m_fc, m_dc;
    logic [SW-1:0] m_cur[$];
    logic [SW-1:0] m_host[DEPTH];
    logic [31:0] m_res[DEPTH];

    logic [31:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [32*DEPTH-1:0] act, input logic [32*DEPTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [SW-1:0] v);
        return {{(32-SW){v[SW-1]}}, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_fr = 0; m_full = 0; m_bank = 0;
        m_busy = -10; m_fc = 16'd0; m_dc = 16'd0;
        m_cur.delete();
        for (int k = 0; k < DEPTH; k++) m_res[k] = 32'd0;
    endtask

    task automatic do_swap(input int busy_cycle);
        for (int i = 0; i < DEPTH; i++) m_host[i] = m_cur[i];
        m_cur.delete();
        m_fr = 1; m_full = 0; m_fc++; m_bank = ~m_bank;
        m_busy = busy_cycle;
    endtask

    task automatic send(input logic [SW-1:0] v);
        int c = cyc;
        if (m_en) begin
            if (m_full || c == m_busy) begin
                if (m_dc != 16'hFFFF) m_dc++;
            end else begin
                m_cur.push_back(v);
                if (m_cur.size() == DEPTH) begin
                    if (!m_fr) do_swap(c + 1);
                    else m_full = 1;
                end
            end
        end
        SAMPLE_IN = v;
        SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic feed_rand(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, max_gap));
            send(SW'($urandom()));
        end
    endtask

    task automatic avl_write(input int addr, input logic [31:0] d, input logic [3:0] be);
        int c = cyc;
        if (addr >= DEPTH && addr < 2 * DEPTH) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_res[addr-DEPTH][8*b +: 8] = d[8*b +: 8];
        end else if (addr == CTRL) begin
            m_en = d[0];
            m_ie = d[2];
            if (!m_en) begin
                m_cur.delete();
                m_full = 0;
            end
            if (d[3]) begin
                m_fc = 16'd0;
                m_dc = 16'd0;
            end
            if (d[1] && m_fr) begin
                m_fr = 0;
                if (m_full) do_swap(c + 1);
            end
        end
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(addr);
        AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        tick();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input int addr, input string name);
        logic [31:0] e;
        if (addr < DEPTH) e = sx(m_host[addr]);
        else if (addr < 2 * DEPTH) e = m_res[addr-DEPTH];
        else if (addr == CTRL) e = {27'd0, m_bank, m_fr, m_ie, 1'b0, m_en};
        else if (addr == STAT) e = {m_dc, m_fc};
        else e = 32'd0;
        exp_q.push_back(e);
        name_q.push_back($sformatf("%s@%0d", name, addr));
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = AW'(addr);
        tick();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
    endtask

    task automatic read_bank(input string name);
        for (int i = 0; i < DEPTH; i++) avl_read(i, name);
    endtask

    task automatic side_check(input string name);
        check({name, "_irq"}, (32*DEPTH)'(IRQ), (32*DEPTH)'(m_fr & m_ie));
        check({name, "_export"}, (32*DEPTH)'(EXPORT_DATA), (32*DEPTH)'({m_dc, m_fc}));
    endtask

    task automatic reset_checks(input string name);
        check({name, "_readdata"}, (32*DEPTH)'(AVL_READDATA), '0);
        check({name, "_irq"}, (32*DEPTH)'(IRQ), '0);
        check({name, "_export"}, (32*DEPTH)'(EXPORT_DATA), '0);
        check({name, "_result_out"}, RESULT_OUT, '0);
    endtask

    task automatic result_out_check(input string name);
        logic [32*DEPTH-1:0] e = '0;
        for (int k = 0; k < DEPTH; k++) e[32*(DEPTH-1-k) +: 32] = m_res[k];
        check(name, RESULT_OUT, e);
    endtask

    // Monitor: every accepted read yields one READDATA word on the next cycle.
    initial begin
        logic [31:0] e;
        string n;
        forever begin
            @(posedge clk);
            if (AVL_CS && AVL_READ) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got %h expected no read", AVL_READDATA);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, (32*DEPTH)'(AVL_READDATA), (32*DEPTH)'(e));
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        RESET = 1'b1; AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0; AVL_BYTE_EN = 4'h0;
        AVL_ADDR = '0; AVL_WRITEDATA = 32'd0; SAMPLE_IN = '0; SAMPLE_VALID = 0;
        model_reset();
        idle(3);
        RESET = 1'b0;
        reset_checks("reset");
        avl_read(CTRL, "ctrl_rst");
        avl_read(STAT, "status_rst");

        // First frame 1..8
        avl_write(CTRL, 32'h5, 4'hF);
        idle(2);
        for (int i = 1; i <= DEPTH; i++) begin
            idle($urandom_range(0, 1));
            send(SW'(i));
        end
        idle(3);
        side_check("frame1");
        read_bank("frame1");
        avl_read(STAT, "status1");

        // Second frame without ACK, then three dropped samples
        for (int i = 9; i <= 16; i++) send(SW'(i));
        feed_rand(3, 1);
        idle(3);
        read_bank("held");
        avl_read(STAT, "status_drop");
        side_check("held");

        // ACK releases the waiting frame
        avl_write(CTRL, 32'h7, 4'hF);
        idle(3);
        read_bank("after_ack");
        avl_read(STAT, "status_ack");
        avl_read(CTRL, "ctrl_ack");
        side_check("after_ack");

        // Random frames with back-to-back and gapped streams
        for (int f = 0; f < 4; f++) begin
            avl_write(CTRL, 32'h7, 4'hF);
            if (f == 0) begin
                idle(1);
                send(24'h800001);
            end
            feed_rand(DEPTH + $urandom_range(0, 3), (f == 1) ? 0 : 2);
            idle(3);
            read_bank("rand");
            avl_read(STAT, "status_rand");
            avl_read(CTRL, "ctrl_rand");
            side_check("rand");
        end

        // Result array
        avl_write(DEPTH + 2, 32'hDEAD_BEEF, 4'hF);
        avl_write(DEPTH + 2, 32'h0000_0012, 4'b0001);
        avl_read(DEPTH + 2, "result_be");
        check("result_out_slot2", (32*DEPTH)'(RESULT_OUT[32*(DEPTH-2)-1 -: 32]), (32*DEPTH)'(32'hDEAD_BE12));
        for (int k = 0; k < DEPTH; k++) begin
            d = $urandom();
            avl_write(DEPTH + k, d, 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < DEPTH; k++) avl_read(DEPTH + k, "result_rand");
        result_out_check("result_out_all");
        avl_write(STAT + 2, 32'h1234_5678, 4'hF);
        avl_read(STAT + 2, "unmapped");
        avl_read((1 << AW) - 1, "unmapped_top");
        avl_write(3, 32'hFFFF_FFFF, 4'hF);
        avl_read(3, "sample_ro");

        // CLR zeroes both counters
        avl_write(CTRL, 32'hD, 4'hF);
        idle(1);
        avl_read(STAT, "status_clr");
        side_check("clr");

        // EN cleared mid-frame discards the partial capture
        avl_write(CTRL, 32'h4, 4'hF);
        idle(2);
        avl_write(CTRL, 32'h6, 4'hF);
        idle(3);
        avl_write(CTRL, 32'h5, 4'hF);
        idle(2);
        feed_rand(5, 1);
        avl_write(CTRL, 32'h4, 4'hF);
        idle(2);
        feed_rand(3, 0);
        avl_write(CTRL, 32'h5, 4'hF);
        idle(2);
        feed_rand(DEPTH, 2);
        idle(3);
        read_bank("en_restart");
        avl_read(STAT, "status_en");
        side_check("en_restart");

        // Reset in the middle of a fill while a frame is still owned by the host
        feed_rand(3, 0);
        RESET = 1'b1;
        idle(2);
        RESET = 1'b0;
        model_reset();
        reset_checks("midreset");
        avl_write(CTRL, 32'h5, 4'hF);
        idle(2);
        feed_rand(DEPTH, 1);
        idle(3);
        read_bank("post_reset");
        avl_read(STAT, "status_post_reset");
        side_check("post_reset");

        idle(3);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rd_pending: got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_frame_buffer.md
# audio_frame_buffer

Parametrised, single-clock successor to the audio data interface. It captures a stream of deserialised audio samples into a ping-pong pair of frame banks, so capture continues while the host (Nios, Avalon-MM) reads the completed frame. It also holds a host-written result array (FFT magnitudes) that is exported in parallel to the display pipeline. It adds ownership handshaking, drop counting, an interrupt and enable/clear control.

## Interface
- DEPTH, 256: samples per frame; also the number of result words; power of two, ≥4
- SAMPLE_W, 24: width of incoming sample; 1..32
- ADDR_W, 11: Avalon word-address width; must satisfy 2*DEPTH+2 ≤ 2^ADDR_W
- CLK  in  1  single clock; all logic on posedge
- RESET  in  1  synchronous, active-high
- AVL_READ / AVL_WRITE / AVL_CS  in  1  Avalon-MM strobes; ignored unless AVL_CS=1
- AVL_BYTE_EN  in  4  byte enables, apply to result-region writes only
- AVL_ADDR  in  ADDR_W  word address
- AVL_WRITEDATA  in  32  write data
- AVL_READDATA  out  32  read data, registered, read latency 1
- SAMPLE_IN  in  SAMPLE_W  sample from I2S deserializer (already in CLK domain)
- SAMPLE_VALID  in  1  single-cycle strobe, one per sample
- IRQ  out  1  frame_ready & CTRL.IE
- RESULT_OUT  out  32*DEPTH  result[0] at MSBs, result[DEPTH-1] at LSBs
- EXPORT_DATA  out  32  mirror of STATUS word

## Operation
- Address map: 0..DEPTH-1 = host bank samples (read-only, sign-extended to 32); DEPTH..2*DEPTH-1 = result[k] (R/W); 2*DEPTH = CTRL; 2*DEPTH+1 = STATUS; other addresses read 0, writes ignored.
- CTRL write: bit0 EN, bit2 IE (stored); bit1 ACK and bit3 CLR are write-1 pulses, read 0. CTRL read: [0] EN, [2] IE, [3] frame_ready, [4] host-bank select.
- STATUS: [15:0] frame_count (wraps), [31:16] drop_count (saturates at 16'hFFFF).
- FSM states:
  - IDLE: EN=0. Samples are discarded and not counted; wptr=0. Goes to FILL when EN=1.
  - FILL: each SAMPLE_VALID writes the capture bank at wptr, then wptr++. The valid at wptr=DEPTH-1 moves to FULL.
  - FULL: if registered frame_ready=0, then in this cycle swap bank select, set frame_ready=1, increment frame_count, set wptr=0, go to FILL. Otherwise wait. Any SAMPLE_VALID while in FULL (including the swap cycle) is dropped and drop_count++.
- EN cleared in FILL or FULL goes to IDLE next cycle. The partial capture is discarded. The host bank and frame_ready are untouched.
- ACK with frame_ready=1 clears frame_ready the next cycle. ACK with frame_ready=0 has no effect.
- If a swap and an ACK write land in the same cycle, the swap wins and frame_ready=1.
- CLR zeroes frame_count and drop_count. If CLR coincides with an increment, CLR wins.
- Result writes are byte-enabled. RESULT_OUT reflects a write on the cycle after it.

## Timing
- Reset: state IDLE, bank select 0, wptr 0, frame_ready 0, CTRL 0, counters 0, all results 0. Reset values of AVL_READDATA, IRQ, RESULT_OUT and EXPORT_DATA are 0.
- AVL_READDATA is valid on the cycle after AVL_READ&AVL_CS. It holds its value until the next read.
- Write-to-read visibility: a read issued the cycle after a write returns the new value.
- Final sample valid at cycle t: FULL at t+1. If frame_ready=0, the swap happens at t+1, and frame_ready and IRQ rise at t+2.
- ACK written at cycle t: frame_ready=0 at t+1. A waiting FULL swaps at t+1, so frame_ready=1 again at t+2.
- Back-to-back SAMPLE_VALID every cycle must be supported in FILL.

## Structure
- Package audio_fb_pkg holds:
  - register offsets as functions of DEPTH
  - CTRL bit positions
  - the state enum {FB_IDLE, FB_FILL, FB_FULL}
- Sample storage is an array of 2*DEPTH words (bank-indexed) suitable for block-RAM inference. Its read port is synchronous, which matches read latency 1.
- Sub-module audio_fb_fsm contains state, wptr, bank select, frame_ready and the counters. The top module holds the Avalon decode, the result registers and storage.

## Test plan
- DEPTH=8: EN=1, feed samples 1..8, read 0..7 → 1..8. STATUS=32'h0000_0001, IRQ=1 (with IE=1).
- Feed samples 9..16 without ACK → host bank still reads 1..8. Then 3 more samples → drop_count=3. ACK → swap; bank reads 9..16, frame_count=2.
- Sample SAMPLE_W=24 value 24'h800001 → read returns 32'hFF80_0001.
- Write result[2]=32'hDEAD_BEEF, then BYTE_EN=4'b0001 with data 32'h0000_0012 → read returns 32'hDEAD_BE12. RESULT_OUT shows this value at bits [32*(DEPTH-2)-1 -: 32].
- Clear EN after 5 samples, then set EN, feed 8 samples → the frame contains only the new 8 samples and frame_count increments by 1.
- Assert RESET mid-FILL with frame_ready=1 → all outputs 0, state IDLE, next frame starts at index 0.
